// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the data-memory access stage.
// Used by mem_access_stage and mem_timeout_counter.
package mem_stage_pkg;

    localparam int TO_W   = 16;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles; expired flags the last allowed cycle without an ack.
// TIMEOUT_CYCLES of 0 disables expiry.
module mem_timeout_counter
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds completed BUSY cycles, so LAST marks the final one
    assign expired = enable
                   && (TIMEOUT_CYCLES != 0)
                   && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Data-memory access stage: EX/MEM load/store to valid/ack port, with timeout.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses without a request.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] write_data_in,
    output logic              stall,
    output logic              RegWrite_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic              bus_error,
    output logic              misalign_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_write_q, is_write_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;
    logic              access;
    logic              misaligned;
    logic              expired;

    assign access = MemRead_in | MemWrite_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |addr_in[1:0];
`else
    logic unused_lo;
    assign unused_lo  = ^addr_in[1:0];
    assign misaligned = 1'b0;
`endif

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != BUSY),
        .enable (state_q == BUSY),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        mis_d      = mis_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d     = {addr_in[ADDR_W-1:2], 2'b00};
                    wdata_d    = write_data_in;
                    is_write_d = MemWrite_in;
                    if (misaligned) begin
                        mis_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // ack beats a same-cycle timeout
                if (dmem_ack) begin
                    rdata_d = is_write_q ? '0 : dmem_rdata;
                    state_d = DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                mis_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            mis_q      <= mis_d;
        end
    end

    assign stall = ~reset
                 & (((state_q == IDLE) & access) | (state_q == BUSY));

    assign dmem_req      = (state_q == BUSY);
    assign dmem_we       = dmem_req & is_write_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign read_data_out = rdata_q;
    assign bus_error     = err_q;
    assign misalign_err  = mis_q;
    assign RegWrite_out  = RegWrite_in & ~stall & ~bus_error & ~misalign_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage (TIMEOUT_CYCLES=8).
// Expectations come from a transaction-level model and a word memory array.
module tb_mem_access_stage;

  localparam int TO = 8;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_in, MemWrite_in, RegWrite_in;
  logic [31:0] addr_in, write_data_in;
  logic        stall, RegWrite_out, bus_error, misalign_err;
  logic [31:0] read_data_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] model_mem [bit [29:0]];
  logic [31:0] slave_mem [bit [29:0]];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_access_stage #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .RegWrite_in  (RegWrite_in),
    .addr_in      (addr_in),
    .write_data_in(write_data_in),
    .stall        (stall),
    .RegWrite_out (RegWrite_out),
    .read_data_out(read_data_out),
    .bus_error    (bus_error),
    .misalign_err (misalign_err),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input bit [29:0] w);
    return model_mem.exists(w) ? model_mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] slave_rd(input bit [29:0] w);
    return slave_mem.exists(w) ? slave_mem[w] : 32'h0;
  endfunction

  task automatic idle(input int n);
    logic rw;
    for (int i = 0; i < n; i++) begin
      rw            = 1'($urandom);
      MemRead_in    = 1'b0;
      MemWrite_in   = 1'b0;
      RegWrite_in   = rw;
      addr_in       = $urandom;
      write_data_in = $urandom;
      dmem_ack      = 1'($urandom);
      dmem_rdata    = $urandom;
      @(negedge clk);
      chk("idle_stall", stall, 1'b0);
      chk("idle_req", dmem_req, 1'b0);
      chk("idle_regwrite", RegWrite_out, rw);
      chk("idle_rdata_hold", read_data_out, last_rd);
      chk("idle_buserr", bus_error, 1'b0);
      @(posedge clk);
      #1;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input bit rw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int n_ack);
    bit          mis;
    bit          acked;
    bit          err;
    int          busy;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    mis      = ALIGN && (a[1:0] != 2'b00);
    acked    = !mis && n_ack > 0 && n_ack <= TO;
    err      = !mis && !acked;
    busy     = mis ? 0 : (acked ? n_ack : TO);
    exp_addr = {a[31:2], 2'b00};
    exp_rd   = (wr || !acked) ? 32'h0 : model_rd(a[31:2]);
    if (wr && acked) model_mem[a[31:2]] = wd;
    MemRead_in    = rd;
    MemWrite_in   = wr;
    RegWrite_in   = rw;
    addr_in       = a;
    write_data_in = wd;
    for (int c = 0; c <= busy + 1; c++) begin
      dmem_ack   = (c >= 1) && (c <= busy) && (c == n_ack);
      dmem_rdata = $urandom;
      if (dmem_ack && dmem_req) begin
        if (dmem_we) slave_mem[dmem_addr[31:2]] = dmem_wdata;
        else dmem_rdata = slave_rd(dmem_addr[31:2]);
      end
      @(negedge clk);
      if (c == 0) begin
        chk("req_stall", stall, 1'b1);
        chk("req_no_dmem", dmem_req, 1'b0);
        chk("req_regwrite", RegWrite_out, 1'b0);
      end else if (c <= busy) begin
        chk("busy_stall", stall, 1'b1);
        chk("busy_req", dmem_req, 1'b1);
        chk("busy_we", dmem_we, wr);
        chk("busy_addr", dmem_addr, exp_addr);
        chk("busy_wdata", dmem_wdata, wd);
        chk("busy_regwrite", RegWrite_out, 1'b0);
      end else begin
        chk("done_stall", stall, 1'b0);
        chk("done_req", dmem_req, 1'b0);
        chk("done_rdata", read_data_out, exp_rd);
        chk("done_buserr", bus_error, err);
        chk("done_misalign", misalign_err, mis);
        chk("done_regwrite", RegWrite_out, rw && !err && !mis);
      end
      @(posedge clk);
      #1;
    end
    last_rd     = exp_rd;
    dmem_ack    = 1'b0;
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    MemRead_in    = 1'b1;
    MemWrite_in   = 1'b0;
    RegWrite_in   = 1'b0;
    addr_in       = 32'h40;
    write_data_in = 32'h0;
    dmem_ack      = 1'b0;
    dmem_rdata    = 32'h0;
    last_rd       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_stall_forced", stall, 1'b0);
    chk("reset_req", dmem_req, 1'b0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    MemRead_in = 1'b0;
    @(negedge clk);
    chk("rst_rdata", read_data_out, 32'h0);
    chk("rst_buserr", bus_error, 1'b0);
    chk("rst_misalign", misalign_err, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    @(posedge clk);
    #1;
    idle(3);

    model_mem[30'h4] = 32'hDEAD_BEEF;
    slave_mem[30'h4] = 32'hDEAD_BEEF;
    access(1, 0, 1, 32'h10, 32'h0, 1);
    idle(1);
    access(0, 1, 1, 32'h20, 32'h1234_5678, 4);
    idle(1);
    access(1, 0, 1, 32'h10, 32'h0, 0);
    idle(1);
    access(1, 0, 1, 32'h10, 32'h0, TO);
    access(1, 1, 0, 32'h24, 32'hCAFE_F00D, 1);
    access(1, 0, 1, 32'h20, 32'h0, 1);
    access(1, 0, 1, 32'h24, 32'h0, 1);
    access(1, 0, 1, 32'h06, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      access(k != 1, k != 0, 1'($urandom),
             32'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 10));
      idle($urandom_range(0, 2));
    end

    MemRead_in  = 1'b1;
    RegWrite_in = 1'b0;
    addr_in     = 32'h30;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_busy", dmem_req, 1'b1);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    MemRead_in = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy_req", dmem_req, 1'b0);
    chk("rst_busy_stall", stall, 1'b0);
    chk("rst_busy_rdata", read_data_out, 32'h0);
    chk("rst_busy_addr", dmem_addr, 32'h0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late_ack_req", dmem_req, 1'b0);
    chk("late_ack_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", read_data_out, 32'h0);
    chk("late_ack_buserr", bus_error, 1'b0);
    @(posedge clk);
    #1;
    last_rd = 32'h0;
    access(1, 0, 1, 32'h24, 32'h0, 2);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Data-memory access stage of the five-stage pipeline, sitting between the EX/MEM register and the MEM/WB register. Turns a load or store from EX/MEM into a valid/ack transaction on the data-memory port and stalls the upstream pipeline until the transaction completes. Returns the load data and gated writeback controls to MEM/WB. A timeout counter converts a missing acknowledge into a bus error.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before abort. 0 disables the timeout. Maximum 65535.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- MemRead_in  in  1  load request from EX/MEM.
- MemWrite_in  in  1  store request from EX/MEM.
- RegWrite_in  in  1  writeback enable from EX/MEM.
- addr_in  in  32  byte address (ALU result).
- write_data_in  in  32  store data.
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- RegWrite_out  out  1  RegWrite_in & ~stall & ~bus_error & ~misalign_err; feeds MEM/WB.
- read_data_out  out  32  load data; feeds MEM/WB read_data.
- bus_error  out  1  one-cycle pulse on timeout.
- misalign_err  out  1  one-cycle pulse on a misaligned access.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  write strobe, qualified by dmem_req.
- dmem_addr  out  32  word address; bits [1:0] are always 0.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- dmem_ack  in  1  transaction complete.

## Operation
States:
- IDLE: no transaction pending. If MemRead_in or MemWrite_in is high:
  - drive stall=1 combinationally;
  - latch addr_in, write_data_in and is_write = MemWrite_in (MemWrite has priority when both are high);
  - go to BUSY.
  - With no access, stall=0 and RegWrite passes through.
- BUSY: dmem_req=1, with dmem_we, dmem_addr and dmem_wdata taken from the latches and held stable.
  - stall=1; the counter increments each cycle.
  - dmem_ack=1: capture dmem_rdata (reads only; writes capture 0), then go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: set err_q, capture 0, go to DONE.
- DONE: dmem_req=0 and stall=0.
  - read_data_out holds the captured value; bus_error=err_q.
  - EX/MEM advances and MEM/WB captures on this edge.
  - Go to IDLE, and clear the counter and err_q.
- The next access is recognised in IDLE on the following cycle. DONE never starts a transaction.
- dmem_ack outside BUSY is ignored.
- Reset in any state: return to IDLE and drop dmem_req at the next edge. An abandoned memory transaction is not tracked.
- Reset values: every output is 0, and stall is forced to 0 while reset is high.

## Timing
- Load or store with ack in the first BUSY cycle: 3 cycles per access (IDLE, BUSY, DONE), 2 of them stalled.
- Ack after N BUSY cycles: N+1 stall cycles.
- Timeout: exactly TIMEOUT_CYCLES BUSY cycles, then DONE with bus_error=1 and RegWrite_out=0.
- Ack and timeout in the same cycle: ack wins and no error is raised.
- Non-memory instructions: zero added latency; outputs pass through combinationally.
- read_data_out is registered. It is valid in DONE and holds until the next capture.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access in IDLE with addr_in[1:0] != 0 issues no request and goes directly to DONE.
  - In DONE: misalign_err=1, RegWrite_out=0, read_data_out=0.
  - Cost: 1 stall cycle.
- MEM_ALIGN_CHECK_EN undefined:
  - misalign_err is tied to 0.
  - addr_in[1:0] is dropped silently and the access proceeds normally.

## Structure
- mem_stage_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the counter width constant TO_W=16;
  - ADDR_W=32 and DATA_W=32.
- Sub-module mem_timeout_counter (inputs: clear, enable; output: expired) holds the TIMEOUT_CYCLES comparison, including the 0 = disabled case.

## Test plan
- Load from 0x0000_0010, ack in the first BUSY cycle with rdata 0xDEAD_BEEF: stall high for 2 cycles; DONE shows read_data_out=0xDEAD_BEEF and RegWrite_out=1; dmem_we=0 throughout.
- Store of 0x1234_5678 to 0x20, ack after 4 cycles: dmem_req high for exactly 4 cycles, dmem_we=1, dmem_addr=0x20 held stable, 5 stall cycles, read_data_out=0.
- TIMEOUT_CYCLES=8 with no ack: 8 BUSY cycles, then a one-cycle bus_error pulse, RegWrite_out=0, read_data_out=0, and return to IDLE.
- Back-to-back loads with immediate acks: each takes 3 cycles and the second request rises the cycle after DONE. MemRead and MemWrite both high produces a write.
- Reset asserted in BUSY: next cycle dmem_req=0, stall=0, all outputs 0. A late ack after reset has no effect.
- With MEM_ALIGN_CHECK_EN, a load from 0x0000_0006 gives no dmem_req, 1 stall cycle and misalign_err=1. Without the macro the same load reads word 0x0000_0004.
